// File: rtl/d_flip_flop.sv
// Parameterised D-type register chain: STAGES cascaded WIDTH-bit registers with
// clock enable, synchronous clear and asynchronous active-low reset.

module d_flip_flop_checker #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input logic             CLK,
    input logic             RST_N,
    input logic             SCLR,
    input logic [WIDTH-1:0] Q,
    input logic [WIDTH-1:0] QN
);

    qn_complement_a : assert property (@(posedge CLK) disable iff (!RST_N) QN == ~Q);

    sclr_clears_a : assert property (@(posedge CLK) disable iff (!RST_N)
        SCLR |=> (Q == RESET_VALUE));

endmodule

module d_flip_flop #(
    parameter int               WIDTH       = 1,
    parameter int               STAGES      = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    output logic [WIDTH-1:0] Q,
    input  logic [WIDTH-1:0] D,
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             EN,
    input  logic             SCLR,
    output logic [WIDTH-1:0] QN
);

    logic [WIDTH-1:0] stage_r     [STAGES];
    logic [WIDTH-1:0] stage_nxt_s [STAGES];

    // Next-state: clear beats enable; with EN low the whole chain holds.
    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            stage_nxt_s[i] = stage_r[i];
        end
        if (SCLR) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_nxt_s[i] = RESET_VALUE;
            end
        end else if (EN) begin
            stage_nxt_s[0] = D;
            for (int i = 1; i < STAGES; i++) begin
                stage_nxt_s[i] = stage_r[i-1];
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                stage_nxt_s[i] = stage_r[i];
            end
        end
    end

    // Stage registers; reset discards everything in flight.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_r[i] <= RESET_VALUE;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                stage_r[i] <= stage_nxt_s[i];
            end
        end
    end

    assign Q  = stage_r[STAGES-1];
    assign QN = ~Q;

    d_flip_flop_checker #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_checker (
        .CLK   (CLK),
        .RST_N (RST_N),
        .SCLR  (SCLR),
        .Q     (Q),
        .QN    (QN)
    );

endmodule

// File: tb/tb_d_flip_flop.sv
// Scoreboard bench for d_flip_flop: stimulus pushes expected Q values, a monitor
// pops and compares them after each rising edge or on an explicit mid-cycle kick.

module tb_d_flip_flop;

    typedef struct {
        string      name;
        int         inst;
        logic [7:0] eq;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic       clk_s      = 1'b0;
    logic       mon_kick_s = 1'b0;

    logic       d0_s = 1'b0, en0_s = 1'b1, sclr0_s = 1'b0, rst0_s = 1'b1;
    logic       d1_s = 1'b0, en1_s = 1'b1, sclr1_s = 1'b0, rst1_s = 1'b1;
    logic [7:0] d2_s = 8'h00;
    logic       en2_s = 1'b1, sclr2_s = 1'b0, rst2_s = 1'b1;
    logic       q0_s, qn0_s, q1_s, qn1_s;
    logic [7:0] q2_s, qn2_s;

    logic [7:0] model_r [3];

    always #5 clk_s = ~clk_s;

    d_flip_flop u0 (
        .Q(q0_s), .D(d0_s), .CLK(clk_s), .RST_N(rst0_s),
        .EN(en0_s), .SCLR(sclr0_s), .QN(qn0_s)
    );

    d_flip_flop #(.WIDTH(1), .STAGES(1), .RESET_VALUE(1'b1)) u1 (
        .Q(q1_s), .D(d1_s), .CLK(clk_s), .RST_N(rst1_s),
        .EN(en1_s), .SCLR(sclr1_s), .QN(qn1_s)
    );

    d_flip_flop #(.WIDTH(8), .STAGES(3), .RESET_VALUE(8'h5A)) u2 (
        .Q(q2_s), .D(d2_s), .CLK(clk_s), .RST_N(rst2_s),
        .EN(en2_s), .SCLR(sclr2_s), .QN(qn2_s)
    );

    task automatic push(input string nm, input int inst, input logic [7:0] eq);
        exp_t e;
        e.name = nm;
        e.inst = inst;
        e.eq   = eq;
        exp_q.push_back(e);
    endtask

    // Wake the monitor between clock edges, then let it finish comparing.
    task automatic kick();
        mon_kick_s = ~mon_kick_s;
        #2;
    endtask

    // Monitor: compare everything queued 1 time unit after each wake-up.
    initial begin
        exp_t       e;
        logic [7:0] aq, aqn, eqn;
        forever begin
            @(posedge clk_s or mon_kick_s);
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                case (e.inst)
                    0: begin aq = {7'b0, q0_s}; aqn = {7'b0, qn0_s}; eqn = {7'b0, ~e.eq[0]}; end
                    1: begin aq = {7'b0, q1_s}; aqn = {7'b0, qn1_s}; eqn = {7'b0, ~e.eq[0]}; end
                    default: begin aq = q2_s; aqn = qn2_s; eqn = ~e.eq; end
                endcase
                n_tests++;
                if (aq !== e.eq || aqn !== eqn) begin
                    n_fail++;
                    $display("FAIL %s: got Q=%h QN=%h, expected Q=%h QN=%h at t=%0t",
                             e.name, aq, aqn, e.eq, eqn, $time);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state of all instances, checked with no clock edge.
        #1;
        rst0_s = 1'b0; rst1_s = 1'b0; rst2_s = 1'b0;
        #2;
        push("reset_u0", 0, 8'h00);
        push("reset_u1", 1, 8'h01);
        push("reset_u2", 2, 8'h5A);
        kick();
        @(negedge clk_s);
        rst0_s = 1'b1; rst1_s = 1'b1; rst2_s = 1'b1;

        // Plain DFF behaviour.
        @(negedge clk_s); d0_s = 1'b1; push("dff_d1", 0, 8'h01);
        @(negedge clk_s); d0_s = 1'b0; push("dff_d0", 0, 8'h00);
        @(negedge clk_s); d0_s = 1'b1; push("dff_d1b", 0, 8'h01);

        // Asynchronous reset mid-cycle, held while D toggles.
        @(negedge clk_s); #2;
        rst0_s = 1'b0;
        push("async_rst", 0, 8'h00);
        kick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_s); d0_s = ~d0_s; push("rst_hold", 0, 8'h00);
        end
        @(negedge clk_s); rst0_s = 1'b1; d0_s = 1'b1; push("rst_release", 0, 8'h01);

        // Clock enable hold and resume.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_s); en0_s = 1'b0; d0_s = 1'b0; push("en_hold", 0, 8'h01);
        end
        @(negedge clk_s); en0_s = 1'b1; push("en_resume", 0, 8'h00);

        // Synchronous clear to RESET_VALUE=1.
        @(negedge clk_s); push("sclr_pre", 1, 8'h00);
        @(negedge clk_s); sclr1_s = 1'b1; push("sclr", 1, 8'h01);
        @(negedge clk_s); sclr1_s = 1'b0; push("sclr_release", 1, 8'h00);
        @(negedge clk_s); #2;
        sclr1_s = 1'b1;
        push("sclr_no_edge", 1, 8'h00);
        kick();
        @(negedge clk_s); push("sclr_edge", 1, 8'h01);
        @(negedge clk_s); sclr1_s = 1'b0; push("sclr_release2", 1, 8'h00);
        @(negedge clk_s); sclr1_s = 1'b1; en1_s = 1'b0; push("sclr_over_en", 1, 8'h01);
        @(negedge clk_s); sclr1_s = 1'b0; en1_s = 1'b1; push("sclr_release3", 1, 8'h00);

        // Three-stage pipeline; chain is all zeros by now.
        @(negedge clk_s); d2_s = 8'hA5; push("pipe_fill0", 2, 8'h00);
        @(negedge clk_s); d2_s = 8'h3C; push("pipe_fill1", 2, 8'h00);
        @(negedge clk_s); d2_s = 8'hFF; push("pipe_a5", 2, 8'hA5);
        @(negedge clk_s); d2_s = 8'h11; push("pipe_3c", 2, 8'h3C);
        @(negedge clk_s); d2_s = 8'h22; push("pipe_ff", 2, 8'hFF);
        @(negedge clk_s); #2;
        rst2_s = 1'b0;
        push("pipe_async_rst", 2, 8'h5A);
        kick();
        @(negedge clk_s); rst2_s = 1'b1; d2_s = 8'h33; push("pipe_flush0", 2, 8'h5A);
        @(negedge clk_s); d2_s = 8'h44; push("pipe_flush1", 2, 8'h5A);
        @(negedge clk_s); d2_s = 8'h55; push("pipe_after_rst", 2, 8'h33);
        @(negedge clk_s); en2_s = 1'b0; d2_s = 8'h66; push("pipe_en_hold", 2, 8'h33);
        @(negedge clk_s); en2_s = 1'b1; d2_s = 8'h77; push("pipe_en_resume", 2, 8'h44);

        // Random phase against a priority-rule reference model.
        model_r[0] = 8'h77; model_r[1] = 8'h55; model_r[2] = 8'h44;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk_s);
            d2_s    = 8'($urandom);
            en2_s   = ($urandom_range(0, 3) != 0);
            sclr2_s = ($urandom_range(0, 9) == 0);
            rst2_s  = ($urandom_range(0, 15) != 0);
            if (!rst2_s || sclr2_s) begin
                for (int i = 0; i < 3; i++) model_r[i] = 8'h5A;
            end else if (en2_s) begin
                model_r[2] = model_r[1];
                model_r[1] = model_r[0];
                model_r[0] = d2_s;
            end
            push("random", 2, model_r[2]);
        end

        @(negedge clk_s);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/d_flip_flop.md
# d_flip_flop

Edge-triggered D-type storage element, parameterised in data width and pipeline depth, used as the basic registering and delay primitive across the design. It captures D on the rising edge of CLK and presents it on Q, with a complementary output QN. Optional clock-enable and synchronous-clear inputs are provided. An asynchronous active-low reset forces all state to a known value. With default parameters and EN=1, SCLR=0 it behaves as a plain single-bit DFF.

## Interface
Parameters:
- WIDTH, 1, data width of D, Q and QN (≥1)
- STAGES, 1, number of cascaded register stages between D and Q (≥1)
- RESET_VALUE, '0 (WIDTH bits), value loaded into every stage by reset or SCLR

Ports:
- CLK  input  1  clock; all state updates on its rising edge
- RST_N  input  1  reset, asynchronous, active-low
- D  input  WIDTH  data in
- EN  input  1  clock enable, active-high
- SCLR  input  1  synchronous clear, active-high
- Q  output  WIDTH  registered data (last stage)
- QN  output  WIDTH  bitwise complement of Q

Positional order is Q, D, CLK, RST_N, EN, SCLR, QN, so that legacy three-port instantiations map Q, D and CLK positionally.

## Operation
- The state is STAGES registers, s[0]..s[STAGES-1]. Q = s[STAGES-1]. QN = ~Q, combinational from state.
- RST_N=0: all s[i] = RESET_VALUE immediately, independent of CLK. State is held while RST_N stays low.
- Rising CLK edge with RST_N=1 resolves in this priority order:
  - SCLR=1: all s[i] = RESET_VALUE. SCLR overrides EN.
  - Else EN=1: s[0] ← D and s[i] ← s[i-1] for i≥1. The whole chain shifts as one.
  - Else (EN=0): all stages hold.
- Falling CLK edges have no effect.
- Reset values: Q = RESET_VALUE and QN = ~RESET_VALUE.
- No X generation from the block itself. An X on D propagates only through stages that capture it.
- WIDTH bits are independent. No arithmetic or width conversion.

## Timing
- Latency D→Q is exactly STAGES enabled rising edges. For STAGES=1, Q equals the D sampled at the most recent enabled rising edge.
- Q and QN update at the rising edge using non-blocking semantics. They must be stable at 1 ps after the edge.
- D must be stable at the rising edge. Changes on the falling edge are captured at the next rising edge.
- Reset assertion is asynchronous: Q changes with no CLK edge required.
- Reset deassertion: the first capture happens at the first rising edge where RST_N=1 is already stable. An edge coincident with deassertion is treated as still in reset.
- RST_N assertion mid-pipeline discards all in-flight data.
- When EN toggles mid-stream, the held cycles do not count toward latency.

## Test plan
- Defaults (WIDTH=1, STAGES=1), EN=1, SCLR=0: set D=1 on the falling edge. Then Q=1 and QN=0 at 1 ps after the next rising edge. Set D=0 on the falling edge. Then Q=0 at 1 ps after the following rising edge.
- Async reset: with Q=1, drive RST_N=0 mid-cycle. Q=0 must appear immediately with no clock edge. Toggle D for 3 cycles while in reset: Q stays 0. Release reset: Q follows D from the next rising edge.
- Enable: Q=1, set EN=0 and D=0 for 3 rising edges. Q must stay 1. Set EN=1: Q=0 after the next rising edge.
- Sync clear: RESET_VALUE=1, Q=0. Assert SCLR=1 with EN=1 and D=0 for one edge: Q=1. SCLR=1 with RST_N=1 and no edge: Q is unchanged.
- Pipeline: WIDTH=8, STAGES=3. Apply D=8'hA5, 8'h3C, 8'hFF on consecutive edges. Q shows 8'hA5 on the third edge, then 8'h3C, then 8'hFF. QN is always ~Q. Assert RST_N=0 mid-stream: Q=RESET_VALUE and all in-flight data is lost.
- Random: 1000 cycles of random D, EN, SCLR and occasional RST_N, checked against a cycle-accurate reference model of the priority rules above.
